// File: rtl/accel_buf_pkg.sv
// Shared definitions for the matmul accelerator buffer, its sequencer and the array feeder.
package accel_buf_pkg;

  localparam int unsigned DataWidthDef = 128;
  localparam int unsigned DepthDef     = 20;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSettle,
    StDrain
  } state_e;

endpackage

// File: rtl/accelerator_buffer_ctrl_buf_out_fifo.sv
// Two-entry {last, data} FIFO that absorbs the buffer read latency on the drain path.
module buf_out_fifo #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_last,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_data [2];
  logic [1:0]            r_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_pop;

  assign o_valid = (r_count != 2'd0);
  assign w_pop   = i_pop && o_valid;
  assign o_data  = r_data[r_rd_ptr];
  assign o_last  = r_last[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_data;
        r_last[r_wr_ptr] <= i_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/accelerator_buffer_ctrl.sv
// Load/drain sequencer for one accelerator_buffer: fills rows from an upstream stream,
// then streams them out in address order, optionally replaying without a reload.
module accelerator_buffer_ctrl
  import accel_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned DEPTH      = DepthDef,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  replay,
  input  logic [CNT_WIDTH-1:0]  row_count,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
);

  localparam logic [CNT_WIDTH-1:0]  DepthCnt = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CntOne   = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

  state_e                r_state;
  state_e                w_state_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_loaded;
  logic [CNT_WIDTH-1:0]  r_rp;
  logic [ADDR_WIDTH-1:0] r_wp;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_done;
  logic                  r_cmd_err;

  logic                  w_cmd_bad;
  logic                  w_accept;
  logic                  w_load_hs;
  logic                  w_load_last;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_pop_last;
  logic [2:0]            w_occ;
  logic [2:0]            w_occ_limit;
  logic [1:0]            w_fifo_count;
  logic                  w_fifo_valid;
  logic                  w_fifo_last;
  logic [DATA_WIDTH-1:0] w_fifo_data;

  // Replay is only legal over rows that a completed load actually wrote.
  assign w_cmd_bad   = (row_count == '0) || (row_count > DepthCnt) ||
                       (replay && (row_count > r_loaded));
  assign w_accept    = (r_state == StIdle) && start && !w_cmd_bad;
  assign w_load_hs   = (r_state == StLoad) && s_valid;
  assign w_load_last = w_load_hs && (CNT_WIDTH'(r_wp) == (r_cnt - CntOne));

  assign w_pop       = w_fifo_valid && m_ready;
  assign w_pop_last  = w_pop && w_fifo_last;

  // Count the in-flight read against FIFO space so backpressure never overflows it.
  assign w_occ       = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_occ_limit = 3'd2 + {2'b00, w_pop};
  assign w_issue     = (r_state == StDrain) && (r_rp < r_cnt) && (w_occ < w_occ_limit);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = replay ? StDrain : StLoad;
      StLoad:   if (w_load_last) w_state_next = StSettle;
      StSettle: w_state_next = StDrain;
      StDrain:  if (w_pop_last) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt           <= '0;
      r_loaded        <= '0;
      r_rp            <= '0;
      r_wp            <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_en         <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_done          <= 1'b0;
      r_cmd_err       <= 1'b0;
    end else begin
      r_done     <= w_pop_last;
      r_cmd_err  <= (r_state == StIdle) && start && w_cmd_bad;
      r_wr_en    <= w_load_hs;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_cnt <= row_count;
        r_wp  <= '0;
        r_rp  <= '0;
      end
      if (w_load_hs) begin
        r_wr_addr <= r_wp;
        r_wr_data <= s_data;
        r_wp      <= r_wp + AddrOne;
      end
      if (w_load_last) begin
        r_loaded <= r_cnt;
      end
      if (w_issue) begin
        r_rp            <= r_rp + CntOne;
        r_inflight_last <= (r_rp == (r_cnt - CntOne));
      end
    end
  end

  buf_out_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_last  (r_inflight_last),
    .i_data  (buf_rd_data),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_last  (w_fifo_last),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  assign s_ready     = (r_state == StLoad);
  assign busy        = (r_state != StIdle);
  assign done        = r_done;
  assign cmd_err     = r_cmd_err;
  assign buf_wr_en   = r_wr_en;
  assign buf_wr_addr = r_wr_addr;
  assign buf_wr_data = r_wr_data;
  assign buf_rd_addr = r_rp[ADDR_WIDTH-1:0];
  assign m_valid     = w_fifo_valid;
  assign m_data      = w_fifo_data;
  assign m_last      = w_fifo_valid && w_fifo_last;

endmodule

// File: tb/tb_accelerator_buffer_ctrl.sv
// Scoreboard bench for accelerator_buffer_ctrl with a behavioural registered-read buffer.
module tb_accelerator_buffer_ctrl;

  localparam int unsigned DW    = 128;
  localparam int unsigned DEPTH = 20;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          replay = 1'b0;
  logic [CW-1:0] row_count = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
  logic [AW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rd_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic          cmd_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic last; logic [DW-1:0] data;} beat_t;
  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  beat_t exp_q[$];
  wr_t   wq[$];
  bit    tog_mode = 1'b0;

  always #5 clk = ~clk;

  accelerator_buffer_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .replay      (replay),
    .row_count   (row_count),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .busy        (busy),
    .done        (done),
    .cmd_err     (cmd_err)
  );

  // Buffer model: registered write, one-cycle registered read, never cleared.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (buf_wr_en && (buf_wr_addr < AW'(DEPTH))) mem[buf_wr_addr] <= buf_wr_data;
    if (buf_rd_addr < AW'(DEPTH)) buf_rd_data <= mem[buf_rd_addr];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = tog_mode ? ~m_ready : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every downstream handshake and write strobe.
  initial begin
    logic  exp_done;
    logic  stall_prev;
    beat_t stall_beat;
    beat_t b;
    wr_t   w;
    exp_done   = 1'b0;
    stall_prev = 1'b0;
    stall_beat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done   = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (exp_done || done) chk("done_pulse", done, exp_done);
        exp_done = 1'b0;
        if (stall_prev && m_valid) begin
          chk("stall_data", m_data, stall_beat.data);
          chk("stall_last", m_last, stall_beat.last);
        end
        stall_prev = m_valid && !m_ready;
        stall_beat = {m_last, m_data};
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", m_data);
          end else begin
            b = exp_q.pop_front();
            chk("m_data", m_data, b.data);
            chk("m_last", m_last, b.last);
            exp_done = b.last;
          end
        end
        if (buf_wr_en) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%0h required=none", buf_wr_addr);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", buf_wr_addr, w.addr);
            chk("wr_data", buf_wr_data, w.data);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rp, input int rc, input logic exp_err, input logic exp_busy);
    start     = 1'b1;
    replay    = rp;
    row_count = CW'(rc);
    @(posedge clk);
    #1;
    start  = 1'b0;
    replay = 1'b0;
    chk("cmd_err", cmd_err, exp_err);
    chk("busy_after_start", busy, exp_busy);
  endtask

  task automatic push_exp(input int n, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.last = (i == n - 1);
      b.data = base + DW'(i);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_rows(input int n, input logic [DW-1:0] base);
    wr_t w;
    bit  hs;
    int  g;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + DW'(i);
      w.addr  = AW'(i);
      w.data  = base + DW'(i);
      wq.push_back(w);
      hs = 1'b0;
      g  = 0;
      while (!hs && g < 100) begin
        @(negedge clk);
        hs = s_ready;
        @(posedge clk);
        #1;
        g++;
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL load_timeout actual=no_ready required=ready row=%0d", i);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit sr_seen);
    int g;
    g       = 0;
    sr_seen = 1'b0;
    while (busy && g < maxc) begin
      @(posedge clk);
      #1;
      if (s_ready) sr_seen = 1'b1;
      g++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_wr_en", buf_wr_en, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("rst_wr_addr", buf_wr_addr, '0);
    chk("rst_wr_data", buf_wr_data, '0);
    chk("rst_rd_addr", buf_rd_addr, '0);
    chk("rst_m_data", m_data, '0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit seen;
    #1 rst = 1'b1;
    #2 chk_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1);

    // Four rows, no stalls: check write cadence, drain latency and done timing.
    push_exp(4, 128'hA0);
    issue(1'b0, 4, 1'b0, 1'b1);
    send_rows(4, 128'hA0);
    chk("settle_s_ready", s_ready, 1'b0);
    cyc(1);
    chk("drain_entry_m_valid", m_valid, 1'b0);
    cyc(1);
    chk("drain_plus1_m_valid", m_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("b2b_m_valid", m_valid, 1'b1);
    end
    cyc(1);
    chk("done_after_last", done, 1'b1);
    chk("busy_after_last", busy, 1'b0);
    cyc(1);

    // Replay three of the four loaded rows, then an over-long replay.
    push_exp(3, 128'hA0);
    issue(1'b1, 3, 1'b0, 1'b1);
    wait_idle(50, seen);
    chk("replay_no_s_ready", seen, 1'b0);
    cyc(1);
    issue(1'b1, 5, 1'b1, 1'b0);
    cyc(1);

    // Full depth with downstream stalls, plus a start during DRAIN that must be ignored.
    tog_mode = 1'b1;
    push_exp(20, 128'h1000);
    issue(1'b0, 20, 1'b0, 1'b1);
    send_rows(20, 128'h1000);
    cyc(4);
    issue(1'b0, 3, 1'b0, 1'b1);
    wait_idle(200, seen);
    tog_mode = 1'b0;
    cyc(2);

    // Illegal counts.
    issue(1'b0, 0, 1'b0 | 1'b1, 1'b0);
    cyc(1);
    issue(1'b0, 21, 1'b1, 1'b0);
    cyc(1);

    // Single row: address 0 still holds 0x1000, so a premature read would show it.
    push_exp(1, 128'h55);
    issue(1'b0, 1, 1'b0, 1'b1);
    send_rows(1, 128'h55);
    wait_idle(50, seen);
    cyc(2);

    // Reset mid-load, then a replay must be rejected.
    issue(1'b0, 5, 1'b0, 1'b1);
    send_rows(2, 128'h77);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    exp_q.delete();
    wq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1);
    issue(1'b1, 1, 1'b1, 1'b0);
    cyc(3);

    chk("exp_q_empty", DW'(exp_q.size()), '0);
    chk("wq_empty", DW'(wq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accelerator_buffer_ctrl.md
# accelerator_buffer_ctrl

Sequencer for one `accelerator_buffer` instance in the Gemma matmul datapath. It accepts a row-count command and loads that many 128-bit rows from an upstream valid/ready stream into the buffer. It then drains the same rows in address order to the systolic-array feeder over a valid/ready stream, absorbing the buffer's one-cycle registered read latency. A replay mode re-streams the current buffer contents without reloading, for weight reuse.

## Interface
- `DATA_WIDTH`, 128, row width in bits; must match the buffer.
- `DEPTH`, 20, buffer rows.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, buffer address width.
- `CNT_WIDTH`, `$clog2(DEPTH+1)`, row-count width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `replay`  in  1  with `start`: 1 = skip LOAD and drain existing contents.
- `row_count`  in  CNT_WIDTH  rows to load/drain; legal range 1..DEPTH.
- `s_valid`  in  1  upstream row valid.
- `s_data`  in  DATA_WIDTH  upstream row.
- `s_ready`  out  1  high only in LOAD.
- `buf_wr_en`  out  1  buffer write enable.
- `buf_wr_addr`  out  ADDR_WIDTH  buffer write address.
- `buf_wr_data`  out  DATA_WIDTH  buffer write data.
- `buf_rd_addr`  out  ADDR_WIDTH  buffer read address.
- `buf_rd_data`  in  DATA_WIDTH  buffer read data, valid one cycle after address.
- `m_valid`  out  1  downstream row valid.
- `m_data`  out  DATA_WIDTH  downstream row.
- `m_last`  out  1  marks row `row_count-1`.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last drain handshake.
- `cmd_err`  out  1  one-cycle pulse on an illegal `start`.

## Operation
- FSM states:
  - IDLE: `start` with legal `row_count` latches the count.
    - `replay`=0: go to LOAD.
    - `replay`=1: go to DRAIN; this is legal only if `row_count` ≤ the latched `loaded_rows`, otherwise `cmd_err`.
  - LOAD: each `s_valid && s_ready` handshake at write pointer `wp` registers `buf_wr_en`/`buf_wr_addr=wp`/`buf_wr_data=s_data` for the next cycle, then increments `wp`. The handshake with `wp == row_count-1` moves to SETTLE and sets `loaded_rows = row_count`.
  - SETTLE: exactly one cycle, so the final registered write lands before any read. Then go to DRAIN.
  - DRAIN: read pointer `rp` drives `buf_rd_addr`. Returned data enters a 2-entry output FIFO that drives `m_*`. When the FIFO pops the entry tagged last, `done` pulses and the FSM returns to IDLE.
- Read issue rule: issue when `rp < row_count` and `fifo_count + inflight - pop < 2`. This sustains 1 row/cycle with `m_ready` held high and never overflows under backpressure.
- `m_last` is carried as a FIFO tag on the entry read from address `row_count-1`.
- `start` outside IDLE is ignored, with no error.
- `start` with `row_count`=0 or >DEPTH: `cmd_err` pulses and the FSM stays IDLE.
- Reset: all state, pointers, FIFO and `loaded_rows` clear. The buffer array itself is not cleared.

## Timing
- Reset values: `s_ready`, `buf_wr_en`, `m_valid`, `m_last`, `busy`, `done`, `cmd_err` = 0. All addresses and data = 0.
- `start` accepted at edge E: `busy`=1 and state = LOAD (or DRAIN for replay) from E.
- Load: a handshake at edge E produces a buffer write at E+1.
- Drain latency:
  - Address issued in cycle C is read at edge C+1.
  - The row enters the FIFO and `m_valid` rises after edge C+2.
  - First `m_valid` follows entry into DRAIN by 2 cycles.
- A full load of N rows with no stalls takes N cycles in LOAD, then 1 SETTLE cycle, then 2 cycles to first `m_valid`, then N beats.
- `done` is high for the cycle after the last handshake; `busy` falls on that same edge.
- `m_data` and `m_last` hold steady while `m_valid && !m_ready`.
- Asynchronous `rst` mid-LOAD or mid-DRAIN aborts immediately. No `done` pulses, and `loaded_rows` = 0.

## Structure
- Shared package `accel_buf_pkg` holds:
  - the state enum (IDLE, LOAD, SETTLE, DRAIN);
  - the default `DATA_WIDTH`/`DEPTH` constants used by the buffer, this block and the array feeder.
- One sub-module: `buf_out_fifo`, a 2-entry FIFO of {last, data} exposing count/push/pop. Everything else lives in the top module.

## Test plan
- Load 4 rows 0xA0..0xA3 with `s_valid` held high and `m_ready`=1:
  - writes at addresses 0..3 on consecutive cycles;
  - `m_data` A0..A3 back-to-back, `m_last` on A3;
  - `done` one cycle after the A3 handshake.
- DEPTH=20 full load, with `m_ready` toggling every other cycle:
  - all 20 rows out in order, none dropped or duplicated;
  - data stable while stalled.
- `replay`=1, `row_count`=3 after a 4-row load: rows A0..A2 out with no `s_ready` assertion; then `replay` with `row_count`=5 -> `cmd_err`, FSM stays IDLE.
- `start` with `row_count`=0 and with 21 -> `cmd_err` pulse each time, `busy` stays 0. `start` during DRAIN -> ignored.
- `row_count`=1: SETTLE prevents a read-before-write; `m_data` equals the written row, and `m_last`=1 on that single beat.
- `rst` asserted after 2 of 5 loaded rows, then a replay `start` with `row_count`=1:
  - all outputs return to their reset values asynchronously;
  - the replay gives `cmd_err` because `loaded_rows`=0.
